// File: rtl/isp_dgain_pkg.sv
// Shared ISP definitions: Bayer CFA format codes and the phase helper used by
// every stage that must know which colour channel the current pixel belongs to.
package isp_dgain_pkg;

  typedef enum logic [1:0] {
    FMT_R  = 2'd0,
    FMT_GR = 2'd1,
    FMT_GB = 2'd2,
    FMT_B  = 2'd3
  } bayer_fmt_e;

  // The CFA phase of the first pixel is XORed with the line/pixel parity.
  function automatic bayer_fmt_e bayer_format(input logic [1:0] bayer,
                                              input logic       odd_line,
                                              input logic       odd_pix);
    return bayer_fmt_e'(bayer ^ {odd_line, odd_pix});
  endfunction

endpackage

// File: rtl/isp_bayer_phase.sv
// Tracks pixel/line parity inside a frame and reports the Bayer channel of the
// pixel currently on the input bus.
module isp_bayer_phase
  import isp_dgain_pkg::*;
#(
  parameter logic [1:0] BAYER = 2'd0
) (
  input  logic       pclk,
  input  logic       rst_n,
  input  logic       in_href,
  input  logic       in_vsync,
  output logic [1:0] format
);

  logic odd_pix;
  logic odd_line;
  logic href_d;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      odd_pix  <= 1'b0;
      odd_line <= 1'b0;
      href_d   <= 1'b0;
    end else begin
      href_d  <= in_href;
      odd_pix <= in_href ? ~odd_pix : 1'b0;
      // A line ends on the falling edge of href; vsync restarts on an even line.
      if (in_vsync)
        odd_line <= 1'b0;
      else if (href_d && !in_href)
        odd_line <= ~odd_line;
    end
  end

  assign format = bayer_format(BAYER, odd_line, odd_pix);

endmodule

// File: rtl/isp_dgain.sv
// Per-channel digital gain with round-to-nearest and saturation, frame-synchronous
// gain shadowing and a per-frame saturated-pixel counter. Two-cycle latency.
module isp_dgain
  import isp_dgain_pkg::*;
#(
  parameter int BITS      = 8,
  parameter int GAIN_BITS = 12,
  parameter int GAIN_FRAC = 8,
  parameter int CNT_BITS  = 24,
  parameter int BAYER     = 0
) (
  input  logic                 pclk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [GAIN_BITS-1:0] gain_r,
  input  logic [GAIN_BITS-1:0] gain_gr,
  input  logic [GAIN_BITS-1:0] gain_gb,
  input  logic [GAIN_BITS-1:0] gain_b,
  input  logic                 in_href,
  input  logic                 in_vsync,
  input  logic [BITS-1:0]      in_raw,
  output logic                 out_href,
  output logic                 out_vsync,
  output logic [BITS-1:0]      out_raw,
  output logic [CNT_BITS-1:0]  sat_count
);

  localparam int                   PW       = BITS + GAIN_BITS;
  localparam logic [GAIN_BITS-1:0] GAIN_ONE = GAIN_BITS'(1) << GAIN_FRAC;
  localparam logic [PW-1:0]        ROUND    = PW'(1) << (GAIN_FRAC - 1);
  localparam logic [PW-1:0]        PIX_MAX  = {{GAIN_BITS{1'b0}}, {BITS{1'b1}}};

  logic [1:0]           fmt;
  logic                 vsync_prev;
  logic [GAIN_BITS-1:0] act_r, act_gr, act_gb, act_b;
  logic [GAIN_BITS-1:0] sel_gain;

  logic [BITS-1:0]      s1_raw;
  logic [GAIN_BITS-1:0] s1_gain;
  logic                 s1_en, s1_href, s1_vsync;

  logic [PW-1:0]        prod, rounded;
  logic                 sat, sat_event, vs_rise;
  logic [BITS-1:0]      gained;
  logic [CNT_BITS-1:0]  count, count_next;

  isp_bayer_phase #(.BAYER(BAYER[1:0])) u_phase (
    .pclk     (pclk),
    .rst_n    (rst_n),
    .in_href  (in_href),
    .in_vsync (in_vsync),
    .format   (fmt)
  );

  // Gains only take effect at the start of a frame so a frame never mixes gains.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_prev <= 1'b0;
      act_r      <= GAIN_ONE;
      act_gr     <= GAIN_ONE;
      act_gb     <= GAIN_ONE;
      act_b      <= GAIN_ONE;
    end else begin
      vsync_prev <= in_vsync;
      if (in_vsync && !vsync_prev) begin
        act_r  <= gain_r;
        act_gr <= gain_gr;
        act_gb <= gain_gb;
        act_b  <= gain_b;
      end
    end
  end

  always_comb begin
    sel_gain = act_r;
    case (fmt)
      FMT_R:   sel_gain = act_r;
      FMT_GR:  sel_gain = act_gr;
      FMT_GB:  sel_gain = act_gb;
      FMT_B:   sel_gain = act_b;
      default: sel_gain = act_r;
    endcase
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      s1_raw   <= '0;
      s1_gain  <= '0;
      s1_en    <= 1'b0;
      s1_href  <= 1'b0;
      s1_vsync <= 1'b0;
    end else begin
      s1_raw   <= in_raw;
      s1_gain  <= sel_gain;
      s1_en    <= enable;
      s1_href  <= in_href;
      s1_vsync <= in_vsync;
    end
  end

  // PW bits hold the product plus the rounding term without overflow.
  always_comb begin
    prod      = PW'(s1_raw) * PW'(s1_gain);
    rounded   = (prod + ROUND) >> GAIN_FRAC;
    sat       = rounded > PIX_MAX;
    gained    = sat ? {BITS{1'b1}} : rounded[BITS-1:0];
    sat_event = s1_href && s1_en && sat;
    vs_rise   = s1_vsync && !out_vsync;
    count_next = (sat_event && count != {CNT_BITS{1'b1}}) ? count + CNT_BITS'(1) : count;
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      out_raw   <= '0;
      out_href  <= 1'b0;
      out_vsync <= 1'b0;
    end else begin
      out_raw   <= s1_en ? gained : s1_raw;
      out_href  <= s1_href;
      out_vsync <= s1_vsync;
    end
  end

  // The event coinciding with the vsync edge still belongs to the closing frame.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      sat_count <= '0;
    end else if (vs_rise) begin
      sat_count <= count_next;
      count     <= '0;
    end else begin
      count     <= count_next;
    end
  end

endmodule

// File: tb/tb_isp_dgain.sv
// Directed bench for isp_dgain: 2x2 frame vectors on RGGB and BGGR instances,
// plus hand sequences for saturation counting, gain shadowing and mid-line reset.
module tb_isp_dgain;

  typedef struct packed {
    logic [11:0]     g_r, g_gr, g_gb, g_b;
    logic            en;
    logic [3:0][7:0] raw;
    logic [3:0][7:0] e0;
    logic [3:0][7:0] e3;
    int              sat0, sat3;
  } vec_t;

  typedef struct packed {
    logic [7:0] e0;
    logic       c3;
    logic [7:0] e3;
    int         stamp;
  } exp_t;

  logic        pclk, rst_n, enable;
  logic [11:0] gain_r, gain_gr, gain_gb, gain_b;
  logic        in_href, in_vsync;
  logic [7:0]  in_raw;
  logic        out_href, out_vsync, out_href3, out_vsync3;
  logic [7:0]  out_raw, out_raw3;
  logic [23:0] sat_count, sat_count3;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  vec_t vecs[6];

  isp_dgain dut (
    .pclk(pclk), .rst_n(rst_n), .enable(enable),
    .gain_r(gain_r), .gain_gr(gain_gr), .gain_gb(gain_gb), .gain_b(gain_b),
    .in_href(in_href), .in_vsync(in_vsync), .in_raw(in_raw),
    .out_href(out_href), .out_vsync(out_vsync), .out_raw(out_raw), .sat_count(sat_count)
  );

  isp_dgain #(.BAYER(3)) dut3 (
    .pclk(pclk), .rst_n(rst_n), .enable(enable),
    .gain_r(gain_r), .gain_gr(gain_gr), .gain_gb(gain_gb), .gain_b(gain_b),
    .in_href(in_href), .in_vsync(in_vsync), .in_raw(in_raw),
    .out_href(out_href3), .out_vsync(out_vsync3), .out_raw(out_raw3), .sat_count(sat_count3)
  );

  // Clock and cycle counter
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every output pixel must match the oldest expectation, 2 cycles after drive.
  always @(negedge pclk) begin
    exp_t e;
    if (out_href) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_href", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("out_raw", 32'(out_raw), 32'(e.e0));
        chk("latency", 32'(cyc - e.stamp), 32'd2);
        chk("href_b3", 32'(out_href3), 32'd1);
        if (e.c3) chk("out_raw_b3", 32'(out_raw3), 32'(e.e3));
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic set_gains(input logic [11:0] r, gr, gb, b);
    gain_r = r; gain_gr = gr; gain_gb = gb; gain_b = b;
  endtask

  task automatic pixel(input int raw, input int e0, input logic c3, input int e3);
    exp_t e;
    in_href = 1'b1;
    in_raw  = 8'(raw);
    e.e0 = 8'(e0); e.c3 = c3; e.e3 = 8'(e3); e.stamp = cyc;
    exp_q.push_back(e);
    tick();
  endtask

  task automatic end_line();
    in_href = 1'b0;
    tick();
    tick();
  endtask

  // One-cycle vsync; checks vsync latency and the previous frame's saturation count.
  task automatic frame_start(input int prev0, input int prev3);
    in_vsync = 1'b1;
    tick();
    in_vsync = 1'b0;
    chk("out_vsync_lat1", 32'(out_vsync), 32'd0);
    tick();
    chk("out_vsync_hi", 32'(out_vsync), 32'd1);
    chk("sat_count", 32'(sat_count), 32'(prev0));
    chk("sat_count_b3", 32'(sat_count3), 32'(prev3));
    tick();
    chk("out_vsync_lo", 32'(out_vsync), 32'd0);
  endtask

  function automatic logic [31:0] px(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  function automatic vec_t mk(input logic [11:0] r, gr, gb, b, input logic en,
                              input logic [31:0] raw, e0, e3, input int s0, s3);
    vec_t v;
    v.g_r = r; v.g_gr = gr; v.g_gb = gb; v.g_b = b; v.en = en;
    v.raw = raw; v.e0 = e0; v.e3 = e3; v.sat0 = s0; v.sat3 = s3;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int prev0, input int prev3);
    set_gains(v.g_r, v.g_gr, v.g_gb, v.g_b);
    enable = v.en;
    frame_start(prev0, prev3);
    pixel(int'(v.raw[0]), int'(v.e0[0]), 1'b1, int'(v.e3[0]));
    pixel(int'(v.raw[1]), int'(v.e0[1]), 1'b1, int'(v.e3[1]));
    end_line();
    pixel(int'(v.raw[2]), int'(v.e0[2]), 1'b1, int'(v.e3[2]));
    pixel(int'(v.raw[3]), int'(v.e0[3]), 1'b1, int'(v.e3[3]));
    end_line();
  endtask

  initial begin
    int prev0, prev3;
    // Frames are [line0 pix0, line0 pix1, line1 pix0, line1 pix1].
    vecs[0] = mk(12'h180, 12'h080, 12'h100, 12'h100, 1'b1,
                 px(100, 3, 255, 7), px(150, 2, 255, 7), px(100, 3, 128, 11), 0, 0);
    vecs[1] = mk(12'h200, 12'h200, 12'h200, 12'h200, 1'b1,
                 px(200, 127, 128, 0), px(255, 254, 255, 0), px(255, 254, 255, 0), 2, 2);
    vecs[2] = mk(12'h400, 12'h300, 12'h100, 12'h200, 1'b1,
                 px(10, 20, 30, 40), px(40, 60, 30, 80), px(20, 20, 90, 160), 0, 0);
    vecs[3] = mk(12'h200, 12'h200, 12'h200, 12'h200, 1'b0,
                 px(200, 255, 1, 128), px(200, 255, 1, 128), px(200, 255, 1, 128), 0, 0);
    vecs[4] = mk(12'h000, 12'h000, 12'h000, 12'h000, 1'b1,
                 px(255, 1, 0, 77), px(0, 0, 0, 0), px(0, 0, 0, 0), 0, 0);
    vecs[5] = mk(12'h101, 12'h0FF, 12'hFFF, 12'h001, 1'b1,
                 px(254, 255, 1, 255), px(255, 254, 16, 1), px(1, 255, 1, 255), 0, 2);

    // Reset
    rst_n = 1'b0; enable = 1'b1; in_href = 1'b0; in_vsync = 1'b0; in_raw = '0;
    set_gains(12'h100, 12'h100, 12'h100, 12'h100);
    repeat (3) tick();
    chk("rst_out_raw", 32'(out_raw), 32'd0);
    chk("rst_out_href", 32'(out_href), 32'd0);
    chk("rst_out_vsync", 32'(out_vsync), 32'd0);
    chk("rst_sat_count", 32'(sat_count), 32'd0);
    chk("rst_sat_count_b3", 32'(sat_count3), 32'd0);
    rst_n = 1'b1;
    tick();

    // Table-driven frames
    prev0 = 0; prev3 = 0;
    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], prev0, prev3);
      prev0 = vecs[i].sat0;
      prev3 = vecs[i].sat3;
    end

    // Ten saturating pixels, then an empty frame shows the counter restarted.
    set_gains(12'h200, 12'h200, 12'h200, 12'h200);
    enable = 1'b1;
    frame_start(prev0, prev3);
    for (int i = 0; i < 10; i++) pixel(200, 255, 1'b1, 255);
    end_line();
    frame_start(10, 10);
    frame_start(0, 0);

    // Mid-frame gain write must wait for the next vsync.
    set_gains(12'h100, 12'h100, 12'h100, 12'h100);
    frame_start(0, 0);
    pixel(50, 50, 1'b1, 50);
    pixel(60, 60, 1'b1, 60);
    end_line();
    gain_r = 12'h200;
    pixel(70, 70, 1'b0, 0);
    pixel(80, 80, 1'b0, 0);
    end_line();
    pixel(50, 50, 1'b0, 0);
    end_line();
    frame_start(0, 0);
    pixel(50, 100, 1'b1, 50);
    end_line();

    // Reset in the middle of a saturating line.
    set_gains(12'h200, 12'h200, 12'h200, 12'h200);
    frame_start(0, 0);
    for (int i = 0; i < 3; i++) pixel(200, 255, 1'b1, 255);
    end_line();
    frame_start(3, 3);
    for (int i = 0; i < 3; i++) pixel(200, 255, 1'b1, 255);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_raw", 32'(out_raw), 32'd0);
    chk("midrst_out_href", 32'(out_href), 32'd0);
    chk("midrst_sat_count", 32'(sat_count), 32'd0);
    chk("midrst_out_raw_b3", 32'(out_raw3), 32'd0);
    exp_q.delete();
    in_href = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    // Active gains are back to 1.0 until the next vsync latches the 2.0 inputs.
    pixel(60, 60, 1'b1, 60);
    end_line();
    frame_start(0, 0);
    pixel(60, 120, 1'b1, 120);
    end_line();
    tick();

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
